memory_fwd: RTL
===============

Name: memory_fwd

Overview:
- Second-generation single-clock RAM with a strobe/ready interface.
- Adds per-lane write masks and a configurable read pipeline (1 or 2 stages) with full backpressure.
- Read-during-write to the same address is forwarded, so writes are never stalled.
- Drop-in successor for parameter/weight storage: same address/data channel split, one read data master.

Parameters:
- WIDTH, 16: data word width in bits; must be a multiple of LANES.
- DEPTH, 256: number of words; address width AW = $clog2(DEPTH).
- LANES, 2: write-mask lanes; lane width LW = WIDTH/LANES.
- LATENCY, 1: read pipeline stages, 1 or 2; any other value is a $error at elaboration.
- INIT, "": hex file loaded into the array at time zero when non-empty.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_wa_stb  in  1  write address valid.
- s_wa_dat  in  AW  write address.
- s_wa_rdy  out  1  write address accepted.
- s_wd_stb  in  1  write data valid.
- s_wd_dat  in  WIDTH  write data.
- s_wd_msk  in  LANES  lane enables; bit i writes bits [i*LW +: LW].
- s_wd_rdy  out  1  write data accepted.
- s_ra_stb  in  1  read address valid.
- s_ra_dat  in  AW  read address.
- s_ra_rdy  out  1  read address accepted.
- m_rd_rdy  in  1  downstream ready for read data.
- m_rd_stb  out  1  read data valid.
- m_rd_dat  out  WIDTH  read data.

Behaviour:
- Reset:
  - rst low clears all pipeline valids and m_rd_stb, and sets m_rd_dat=0, immediately (not on a clock edge).
  - Array contents are not reset.
  - Reads in flight during reset are discarded.
- Write channel:
  - s_wa_rdy = s_wd_rdy = s_wa_stb & s_wd_stb & rst. Address and data are consumed together; a lone strobe waits.
  - On an accepted write, the array updates at the clock edge, only for lanes with s_wd_msk[i]=1.
  - msk=0 is a legal no-op handshake.
- Read acceptance:
  - A read is accepted when s_ra_stb & s_ra_rdy.
  - Define adv = ~m_rd_stb | m_rd_rdy.
  - LATENCY=1: s_ra_rdy = adv.
  - LATENCY=2: stage-1 valid v1; s_ra_rdy = ~v1 | adv.
- LATENCY=1 pipeline: an accepted read loads m_rd_dat at the next edge and sets m_rd_stb=1.
- LATENCY=2 pipeline:
  - An accepted read captures address and array data into stage 1.
  - Stage 1 moves to the output register when adv holds.
  - Throughput is one read per cycle with no bubbles while m_rd_rdy=1.
- Output hold:
  - If m_rd_stb & m_rd_rdy with no new data arriving, m_rd_stb drops next edge.
  - While m_rd_stb & ~m_rd_rdy, m_rd_dat and m_rd_stb hold stable, and later writes do not alter the held word.
- Forwarding (read-during-write):
  - If a read is accepted in the same cycle as a write to the same address, the captured data is the merged value: new lanes where msk=1, old array lanes elsewhere.
  - LATENCY=2: while stage 1 is valid, any accepted write to the stage-1 address patches stage-1 data lane-wise. The word leaving stage 1 always reflects all writes accepted before it leaves.
- Ordering: read data emerges in acceptance order; no reordering or drops.
- Boundaries:
  - Addresses 0 and DEPTH-1 are fully supported; out-of-range addresses (DEPTH not a power of two) read X and write nothing.
  - Simultaneous write and read to different addresses are independent.

Test Plan:
- Reset/idle: hold rst low 3 cycles, then release -> m_rd_stb=0, m_rd_dat=0, s_ra_rdy=1; write 0x1234 @0x05, then read 0x05 -> m_rd_dat=0x1234 after LATENCY edges.
- Masked write: write 0xAAAA @0x10 msk=11, then 0x5555 msk=01 -> read 0x10 returns 0xAA55; msk=00 write of 0xFFFF leaves 0xAA55.
- Collision forwarding: array[0x20]=0x0000; same cycle write 0xBEEF msk=10 and read 0x20 -> m_rd_dat=0xBE00 (LATENCY 1 and 2).
- Stage-1 patch (LATENCY=2): read 0x30 (holds 0x1111), hold m_rd_rdy=0, next cycle write 0x2222 @0x30 -> emerging word = 0x2222.
- Backpressure: 8 back-to-back reads of addrs 0..7 (data = addr*3) with m_rd_rdy toggling 1,0,0,1 -> all 8 words in order, m_rd_dat stable while stalled, no loss or duplication.
- Async reset mid-stream: assert rst between edges with m_rd_stb=1 and stage 1 valid -> m_rd_stb=0 immediately; nothing emitted after release until a new read.

Source files
------------

// File: rtl/memory_fwd.sv
// Single-clock RAM with lane-masked writes, a 1- or 2-stage read pipeline with
// backpressure, and read-during-write forwarding so writes never stall.
module memory_fwd #(
    parameter int    WIDTH   = 16,
    parameter int    DEPTH   = 256,
    parameter int    LANES   = 2,
    parameter int    LATENCY = 1,
    parameter string INIT    = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_wa_stb,
    input  logic [$clog2(DEPTH)-1:0]   s_wa_dat,
    output logic                       s_wa_rdy,
    input  logic                       s_wd_stb,
    input  logic [WIDTH-1:0]           s_wd_dat,
    input  logic [LANES-1:0]           s_wd_msk,
    output logic                       s_wd_rdy,
    input  logic                       s_ra_stb,
    input  logic [$clog2(DEPTH)-1:0]   s_ra_dat,
    output logic                       s_ra_rdy,
    input  logic                       m_rd_rdy,
    output logic                       m_rd_stb,
    output logic [WIDTH-1:0]           m_rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = WIDTH / LANES;

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("memory_fwd: LATENCY must be 1 or 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [LANES-1:0] msk);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (msk[i]) r[i*LW +: LW] = new_w[i*LW +: LW];
        end
        return r;
    endfunction

    logic             wr_acc, wr_en, ra_acc, ra_ok, adv;
    logic             stb_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] rd_raw, rd_fwd;

    assign wr_acc   = s_wa_stb & s_wd_stb & rst;
    assign wr_en    = wr_acc & (32'(s_wa_dat) < DEPTH);
    assign s_wa_rdy = wr_acc;
    assign s_wd_rdy = wr_acc;
    assign ra_ok    = 32'(s_ra_dat) < DEPTH;
    assign ra_acc   = s_ra_stb & s_ra_rdy;
    assign adv      = ~stb_q | m_rd_rdy;
    assign m_rd_stb = stb_q;
    assign m_rd_dat = dat_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && s_wd_msk[i]) mem_q[s_wa_dat][i*LW +: LW] <= s_wd_dat[i*LW +: LW];
        end
    end

    // Same-cycle write to the read address is merged into the captured word.
    always_comb begin
        rd_raw = ra_ok ? mem_q[s_ra_dat] : 'x;
        rd_fwd = (wr_en && s_wa_dat == s_ra_dat) ? merge(rd_raw, s_wd_dat, s_wd_msk) : rd_raw;
    end

    if (LATENCY == 1) begin : g_lat1
        assign s_ra_rdy = adv;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stb_q <= 1'b0;
                dat_q <= '0;
            end else if (adv) begin
                stb_q <= ra_acc;
                if (ra_acc) dat_q <= rd_fwd;
            end
        end
    end else begin : g_lat2
        logic             v1_q;
        logic [AW-1:0]    a1_q;
        logic [WIDTH-1:0] d1_q, d1_d;

        assign s_ra_rdy = ~v1_q | adv;

        // Stage 1 absorbs writes to its address, including one in its leaving cycle.
        always_comb begin
            d1_d = d1_q;
            if (v1_q && wr_en && s_wa_dat == a1_q) d1_d = merge(d1_q, s_wd_dat, s_wd_msk);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v1_q  <= 1'b0;
                a1_q  <= '0;
                d1_q  <= '0;
                stb_q <= 1'b0;
                dat_q <= '0;
            end else begin
                if (adv) begin
                    stb_q <= v1_q;
                    if (v1_q) dat_q <= d1_d;
                end
                if (ra_acc) begin
                    v1_q <= 1'b1;
                    a1_q <= s_ra_dat;
                    d1_q <= rd_fwd;
                end else begin
                    if (adv) v1_q <= 1'b0;
                    d1_q <= d1_d;
                end
            end
        end
    end

endmodule
